fpu_addsub_issue: RTL and testbench

- Sequential issue/writeback wrapper directly upstream and downstream of the combinational `fsub` unit.
- Accepts add/sub/neg/abs requests on a valid/ready handshake and pre-conditions operands: flushes subnormals to zero and flips the x2 sign for add.
- Drives one `fsub` instance, post-conditions the result (flushes to zero on underflow) and pipelines it LAT cycles.
- Buffers results in an in-order output queue so the FPU register-file writeback can apply backpressure.

---
 rtl/fpu_addsub_issue.sv | 229 ++++++++++++++++++++++
 tb/tb_fpu_addsub_issue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_issue.sv
// Issue/writeback wrapper around a combinational single-precision subtract core.
// Conditions operands and results, pipelines LAT stages and queues results in order.
module fpu_addsub_issue #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_y,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_special,
  output logic             busy
);

  localparam int unsigned CAP = LAT + 1;
  localparam int unsigned CW  = $clog2(CAP + 1);
  localparam int unsigned PW  = $clog2(CAP);

  localparam logic [1:0] OpSub = 2'b00;
  localparam logic [1:0] OpAdd = 2'b01;
  localparam logic [1:0] OpNeg = 2'b10;
  localparam logic [1:0] OpAbs = 2'b11;

  // a - b, round-to-nearest-even; inputs are expected to be subnormal-free.
  function automatic logic [31:0] fsub_core(input logic [31:0] a, input logic [31:0] b);
    logic        sa, sb, sx, sy, eff_sub, rnd_up, found;
    logic [7:0]  ea, eb, ex, ey, diff;
    logic [23:0] mx, my;
    logic [26:0] ax, ay, ay_sh, mask, norm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  e_n;
    logic [24:0] mant;
    logic [31:0] res;
    sa = a[31];
    sb = ~b[31];
    ea = a[30:23];
    eb = b[30:23];
    if (ea == 8'hFF || eb == 8'hFF) begin
      if ((ea == 8'hFF && a[22:0] != 23'd0) || (eb == 8'hFF && b[22:0] != 23'd0)) begin
        res = 32'h7FC0_0000;
      end else if (ea == 8'hFF && eb == 8'hFF) begin
        res = (sa == sb) ? {sa, 8'hFF, 23'd0} : 32'h7FC0_0000;
      end else if (ea == 8'hFF) begin
        res = {sa, 8'hFF, 23'd0};
      end else begin
        res = {sb, 8'hFF, 23'd0};
      end
    end else begin
      if ({ea, a[22:0]} >= {eb, b[22:0]}) begin
        sx = sa; ex = ea; mx = {ea != 8'd0, a[22:0]};
        sy = sb; ey = eb; my = {eb != 8'd0, b[22:0]};
      end else begin
        sx = sb; ex = eb; mx = {eb != 8'd0, b[22:0]};
        sy = sa; ey = ea; my = {ea != 8'd0, a[22:0]};
      end
      diff = ex - ey;
      ax   = {mx, 3'b000};
      ay   = {my, 3'b000};
      mask = '0;
      if (diff >= 8'd27) begin
        ay_sh = {26'd0, |my};
      end else begin
        mask  = (27'd1 << diff) - 27'd1;
        ay_sh = (ay >> diff) | {26'd0, |(ay & mask)};
      end
      eff_sub = sx ^ sy;
      sum = eff_sub ? ({1'b0, ax} - {1'b0, ay_sh}) : ({1'b0, ax} + {1'b0, ay_sh});
      lz     = 5'd0;
      found  = 1'b0;
      norm   = '0;
      e_n    = '0;
      mant   = '0;
      rnd_up = 1'b0;
      if (sum == 28'd0) begin
        // Exact cancellation gives +0 unless both addends were -0.
        res = {sx & sy, 31'd0};
      end else begin
        if (sum[27]) begin
          norm = sum[27:1] | {26'd0, sum[0]};
          e_n  = {2'b00, ex} + 10'd1;
        end else begin
          for (int i = 26; i >= 0; i--) begin
            if (!found) begin
              if (sum[i]) found = 1'b1;
              else        lz    = lz + 5'd1;
            end
          end
          norm = sum[26:0] << lz;
          e_n  = {2'b00, ex} - {5'd0, lz};
        end
        rnd_up = norm[2] & (norm[3] | norm[1] | norm[0]);
        mant   = {1'b0, norm[26:3]} + {24'd0, rnd_up};
        if (mant[24]) begin
          mant = mant >> 1;
          e_n  = e_n + 10'd1;
        end
        if (e_n[9] || e_n == 10'd0) res = {sx, 31'd0};
        else if (e_n >= 10'd255)    res = {sx, 8'hFF, 23'd0};
        else                        res = {sx, e_n[7:0], mant[22:0]};
      end
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(CAP - 1)) ? '0 : p + PW'(1);
  endfunction

  // Operand and result conditioning
  logic [31:0] x1_f, x2_f, x2_s, fsub_y, pre_y, post_y;

  always_comb begin
    x1_f   = (req_x1[30:23] == 8'd0) ? {req_x1[31], 31'd0} : req_x1;
    x2_f   = (req_x2[30:23] == 8'd0) ? {req_x2[31], 31'd0} : req_x2;
    x2_s   = (req_op == OpAdd) ? {~x2_f[31], x2_f[30:0]} : x2_f;
    fsub_y = fsub_core(x1_f, x2_s);
    unique case (req_op)
      OpNeg:   pre_y = {~x1_f[31], x1_f[30:0]};
      OpAbs:   pre_y = {1'b0, x1_f[30:0]};
      OpSub:   pre_y = fsub_y;
      default: pre_y = fsub_y;
    endcase
    post_y = (pre_y[30:23] == 8'd0) ? {pre_y[31], 31'd0} : pre_y;
  end

  // Occupancy and acceptance
  logic          accept, pop, ready_q;
  logic [CW-1:0] cnt_q, cnt_d;

  assign accept = req_valid & ready_q;
  assign pop    = resp_valid & resp_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!accept && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d < CW'(CAP));
    end
  end

  assign req_ready = ready_q;
  assign busy      = (cnt_q != '0);

  // Pipeline: LAT-1 register stages, the queue write is the last stage
  logic             push_v;
  logic [31:0]      push_y;
  logic [TAG_W-1:0] push_tag;

  if (LAT == 1) begin : g_nopipe
    assign push_v   = accept;
    assign push_y   = post_y;
    assign push_tag = req_tag;
  end else begin : g_pipe
    logic [LAT-2:0]   v_q;
    logic [31:0]      y_q   [LAT-1];
    logic [TAG_W-1:0] tag_q [LAT-1];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        v_q <= '0;
      end else begin
        v_q[0] <= accept;
        for (int i = 1; i < int'(LAT) - 1; i++) v_q[i] <= v_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      y_q[0]   <= post_y;
      tag_q[0] <= req_tag;
      for (int i = 1; i < int'(LAT) - 1; i++) begin
        y_q[i]   <= y_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end

    assign push_v   = v_q[LAT-2];
    assign push_y   = y_q[LAT-2];
    assign push_tag = tag_q[LAT-2];
  end

  // In-order result queue
  logic [31:0]      q_y   [CAP];
  logic [TAG_W-1:0] q_tag [CAP];
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    qcnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q <= '0;
      tail_q <= '0;
      qcnt_q <= '0;
    end else begin
      if (push_v) tail_q <= ptr_inc(tail_q);
      if (pop)    head_q <= ptr_inc(head_q);
      if (push_v && !pop)      qcnt_q <= qcnt_q + CW'(1);
      else if (!push_v && pop) qcnt_q <= qcnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_v) begin
      q_y[tail_q]   <= push_y;
      q_tag[tail_q] <= push_tag;
    end
  end

  assign resp_valid   = (qcnt_q != '0);
  assign resp_y       = resp_valid ? q_y[head_q] : '0;
  assign resp_tag     = resp_valid ? q_tag[head_q] : '0;
  assign resp_special = (resp_y[30:23] == 8'hFF);

endmodule

// File: tb/tb_fpu_addsub_issue.sv
// Scoreboard bench for fpu_addsub_issue: directed vectors, in-order response monitor.
module tb_fpu_addsub_issue;

  localparam int unsigned LAT   = 2;
  localparam int unsigned TAG_W = 5;

  localparam logic [1:0] OpSub = 2'b00;
  localparam logic [1:0] OpAdd = 2'b01;
  localparam logic [1:0] OpNeg = 2'b10;
  localparam logic [1:0] OpAbs = 2'b11;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = '0;
  logic [31:0]      req_x1 = '0;
  logic [31:0]      req_x2 = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [31:0]      resp_y;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_special;
  logic             busy;

  fpu_addsub_issue #(.LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_x1       (req_x1),
    .req_x2       (req_x2),
    .req_tag      (req_tag),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_y       (resp_y),
    .resp_tag     (resp_tag),
    .resp_special (resp_special),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;
  bit   rand_rr    = 1'b0;

  // Streaming vectors with hand-computed results
  logic [1:0]  v_op [20] = '{OpSub, OpAdd, OpAdd, OpSub, OpSub, OpAdd, OpAdd, OpNeg, OpAbs, OpNeg,
                             OpAbs, OpAdd, OpAdd, OpSub, OpAdd, OpAdd, OpAdd, OpSub, OpSub, OpSub};
  logic [31:0] v_x1 [20] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                             32'h3FC00000, 32'hBF800000, 32'h40000000, 32'hC0400000, 32'h00000005,
                             32'h80000001, 32'h7F800000, 32'h40800000, 32'h41200000, 32'h3E800000,
                             32'h3F800000, 32'h3F800000, 32'h40000000, 32'h00800001, 32'h7F7FFFFF};
  logic [31:0] v_x2 [20] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000,
                             32'h3F000000, 32'hBF800000, 32'h12345678, 32'h00000000, 32'h3F800000,
                             32'h40000000, 32'h3F800000, 32'h40800000, 32'h40800000, 32'h3F400000,
                             32'h33800000, 32'h34000000, 32'h33800000, 32'h00800000, 32'hFF7FFFFF};
  logic [31:0] v_y  [20] = '{32'h40000000, 32'h40000000, 32'h40400000, 32'h00000000, 32'hBF800000,
                             32'h40000000, 32'hC0000000, 32'hC0000000, 32'h40400000, 32'h80000000,
                             32'h00000000, 32'h7F800000, 32'h41000000, 32'h40C00000, 32'h3F800000,
                             32'h3F800000, 32'h3F800001, 32'h40000000, 32'h00000000, 32'h7F800000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Response monitor: pops the scoreboard on every handshake
  always @(negedge clk) begin
    if (rstn && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_resp: got tag %0d y %h, required no response", resp_tag, resp_y);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_y", resp_y, mon_e.y);
        chk("resp_tag", 32'(resp_tag), 32'(mon_e.tag));
        chk("resp_special", 32'(resp_special), 32'(mon_e.y[30:23] == 8'hFF));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rr) begin
      #1;
      resp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  // Drive one request and hold it until accepted; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] x1, input logic [31:0] x2,
                       input logic [31:0] y, input logic [TAG_W-1:0] tag);
    int   n;
    exp_t e;
    n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_x1    = x1;
    req_x2    = x2;
    req_tag   = tag;
    while (!req_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      compared++;
      mismatched++;
      $display("FAIL issue_timeout: got req_ready 0 for tag %0d, required acceptance", tag);
    end else begin
      e.y   = y;
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int acc;
    exp_t e;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_y", resp_y, 32'd0);
    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
    chk("rst_resp_special", 32'(resp_special), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Latency: result visible exactly LAT cycles after the accepting cycle
    resp_ready = 1'b1;
    issue(OpSub, 32'h40400000, 32'h3F800000, 32'h40000000, 5'd3);
    chk("lat_not_early", 32'(resp_valid), 32'd0);
    chk("busy_inflight", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("lat_exact", 32'(resp_valid), 32'd1);
    drain();

    // Back-to-back mixed ops, flush and overflow cases
    issue(OpAdd, 32'h3F800000, 32'h3F800000, 32'h40000000, 5'd4);
    issue(OpNeg, 32'h3F800000, 32'h00000000, 32'hBF800000, 5'd5);
    issue(OpAbs, 32'hC0000000, 32'h00000000, 32'h40000000, 5'd6);
    issue(OpSub, 32'h00000001, 32'h3F800000, 32'hBF800000, 5'd7);
    issue(OpSub, 32'h00800001, 32'h00800000, 32'h00000000, 5'd8);
    issue(OpSub, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 5'd9);
    drain();

    // Backpressure: capacity LAT+1 with the consumer stalled
    resp_ready = 1'b0;
    acc = 0;
    req_valid = 1'b1;
    req_op    = OpAdd;
    req_x1    = 32'h3F800000;
    req_x2    = 32'h3F800000;
    for (int i = 0; i < 5; i++) begin
      req_tag = TAG_W'(acc);
      if (req_ready) begin
        e.y   = 32'h40000000;
        e.tag = TAG_W'(acc);
        sb.push_back(e);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd3);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    chk("bp_resp_valid", 32'(resp_valid), 32'd1);
    resp_ready = 1'b1;
    chk("bp_ready_before_pop", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("bp_ready_reassert", 32'(req_ready), 32'd1);
    drain();

    // Streaming with a randomly stalling consumer, wrapping the queue many times
    rand_rr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      issue(v_op[i], v_x1[i], v_x2[i], v_y[i], TAG_W'(i + 10));
    end
    rand_rr = 1'b0;
    @(posedge clk);
    #2;
    resp_ready = 1'b1;
    drain();

    // Reset with work in flight and queued
    resp_ready = 1'b0;
    issue(OpAdd, 32'h3F800000, 32'h3F800000, 32'h40000000, 5'd20);
    issue(OpAdd, 32'h3F800000, 32'h40000000, 32'h40400000, 5'd21);
    issue(OpSub, 32'h3F800000, 32'h40000000, 32'hBF800000, 5'd22);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_valid", 32'(resp_valid), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("no_stale_valid", 32'(resp_valid), 32'd0);
    end
    issue(OpAdd, 32'h40800000, 32'h40800000, 32'h41000000, 5'd23);
    drain();

    chk("final_pending", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
